// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with optional skid buffer.
// With SKID=1 the stage has a head (main) entry and a skid entry.
// in_ready then comes straight from a flop, so out_ready never reaches in_ready.
// With SKID=0 there is a single entry, and in_ready depends combinationally on out_ready.
// Control bits read as zero whenever the head slot holds a bubble.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]        occ_q, occ_d;
  logic              accept;
  logic              emit;

  // skid_valid_q is a flop, so the SKID=1 ready has no path from out_ready.
  assign in_ready = (SKID != 0) ? ~skid_valid_q : (~main_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign emit     = main_valid_q & out_ready;

  // Next-state: flush wins, then drain skid->main, then single-entry accept/emit cases.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Full: in_ready is low, so only an emit can happen.
      if (emit) begin
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && emit) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else if (emit) begin
        main_valid_d = 1'b0;
      end else if (accept) begin
        // Only reachable with SKID=1; SKID=0 deasserts in_ready here.
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end
    end else if (accept) begin
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
      main_valid_d = 1'b1;
    end
    occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      occ_q        <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      occ_q        <= occ_d;
    end
  end

  // Outputs: control masked to zero on a bubble, payload held as-is.
  always_comb begin
    out_valid = main_valid_q;
    out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    out_data  = main_data_q;
    occupancy = occ_q;
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage.
// It drives a 2-entry instance (u_skid) and a 1-entry instance (u_one) from the same inputs.
// u_one is built with narrow payload and control fields.
module tb_pipe_skid_stage;

  logic         clk = 1'b0;
  logic         clrn;
  logic         in_valid;
  logic         out_ready;
  logic         flush;
  logic [15:0]  in_ctrl;
  logic [127:0] in_data;

  logic         in_ready1, out_valid1;
  logic [15:0]  out_ctrl1;
  logic [127:0] out_data1;
  logic [1:0]   occ1;

  logic         in_ready0, out_valid0;
  logic [4:0]   out_ctrl0;
  logic [31:0]  out_data0;
  logic [1:0]   occ0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(128), .CTRL_W(16), .SKID(1)) u_skid (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid1),
    .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1)
  );

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(5), .SKID(0)) u_one (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl[4:0]), .in_data(in_data[31:0]), .flush(flush), .out_valid(out_valid0),
    .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0)
  );

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    in_ctrl = 16'hFFFF; in_data = '1;
    step();
    step();
    vecs++;
    if ({out_valid1, occ1, in_ready1, out_ctrl1} !== {1'b0, 2'd0, 1'b1, 16'h0} ||
        out_data1 !== 128'h0) begin
      errs++;
      $display("FAIL reset_skid: got v=%b occ=%0d rdy=%b ctrl=%h data=%h want 0/0/1/0/0",
               out_valid1, occ1, in_ready1, out_ctrl1, out_data1);
    end
    vecs++;
    if ({out_valid0, occ0, in_ready0, out_ctrl0, out_data0} !== {1'b0, 2'd0, 1'b1, 5'h0, 32'h0})
    begin
      errs++;
      $display("FAIL reset_one: got v=%b occ=%0d rdy=%b ctrl=%h data=%h want 0/0/1/0/0",
               out_valid0, occ0, in_ready0, out_ctrl0, out_data0);
    end
    in_valid = 1'b0;
    clrn = 1'b0;
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_data = 128'(k);
      in_ctrl = 16'(k + 16'h0100);
      step();
      vecs++;
      if ({out_valid1, occ1, in_ready1} !== 4'b1011 || out_data1 !== 128'(k) ||
          out_ctrl1 !== 16'(k + 16'h0100)) begin
        errs++;
        $display("FAIL stream_skid k=%0d: got v=%b occ=%0d rdy=%b ctrl=%h data=%h want 1/1/1/%h/%h",
                 k, out_valid1, occ1, in_ready1, out_ctrl1, out_data1, 16'(k + 16'h0100), k);
      end
      vecs++;
      if ({out_valid0, occ0, in_ready0} !== 4'b1011 || out_data0 !== 32'(k) ||
          out_ctrl0 !== 5'(k)) begin
        errs++;
        $display("FAIL stream_one k=%0d: got v=%b occ=%0d rdy=%b ctrl=%h data=%h want 1/1/1/%h/%h",
                 k, out_valid0, occ0, in_ready0, out_ctrl0, out_data0, 5'(k), k);
      end
    end
    in_valid = 1'b0;
    step();
    vecs++;
    if ({out_valid1, occ1, out_ctrl1, out_valid0, occ0, out_ctrl0} !== '0) begin
      errs++;
      $display("FAIL stream_drain: got v1=%b occ1=%0d c1=%h v0=%b occ0=%0d c0=%h want all 0",
               out_valid1, occ1, out_ctrl1, out_valid0, occ0, out_ctrl0);
    end
  endtask

  task automatic test_stall();
    // A then B with downstream stalled.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 128'hA; in_ctrl = 16'h00AA;
    step();
    vecs++;
    if ({out_valid1, occ1, in_ready1} !== 4'b1011 || out_data1 !== 128'hA) begin
      errs++;
      $display("FAIL stall_a_skid: got v=%b occ=%0d rdy=%b data=%h want 1/1/1/a",
               out_valid1, occ1, in_ready1, out_data1);
    end
    vecs++;
    if ({out_valid0, occ0, in_ready0} !== 4'b1010 || out_data0 !== 32'hA) begin
      errs++;
      $display("FAIL stall_a_one: got v=%b occ=%0d rdy=%b data=%h want 1/1/0/a",
               out_valid0, occ0, in_ready0, out_data0);
    end
    in_data = 128'hB; in_ctrl = 16'h00BB;
    step();
    vecs++;
    if ({out_valid1, occ1, in_ready1} !== 4'b1100 || out_data1 !== 128'hA ||
        out_ctrl1 !== 16'h00AA) begin
      errs++;
      $display("FAIL stall_full: got v=%b occ=%0d rdy=%b ctrl=%h data=%h want 1/2/0/00aa/a",
               out_valid1, occ1, in_ready1, out_ctrl1, out_data1);
    end
    vecs++;
    if ({out_valid0, occ0} !== 3'b101 || out_data0 !== 32'hA) begin
      errs++;
      $display("FAIL stall_one_hold: got v=%b occ=%0d data=%h want 1/1/a",
               out_valid0, occ0, out_data0);
    end
    in_data = 128'hC; in_ctrl = 16'h00CC;
    step();
    vecs++;
    if ({occ1, in_ready1} !== 3'b100 || out_data1 !== 128'hA || out_ctrl1 !== 16'h00AA) begin
      errs++;
      $display("FAIL stall_stable: got occ=%0d rdy=%b ctrl=%h data=%h want 2/0/00aa/a",
               occ1, in_ready1, out_ctrl1, out_data1);
    end
    // Release with D offered: full skid stage cannot take D on this edge.
    out_ready = 1'b1; in_data = 128'hD; in_ctrl = 16'h00DD;
    step();
    vecs++;
    if ({out_valid1, occ1, in_ready1} !== 4'b1011 || out_data1 !== 128'hB) begin
      errs++;
      $display("FAIL release1_skid: got v=%b occ=%0d rdy=%b data=%h want 1/1/1/b",
               out_valid1, occ1, in_ready1, out_data1);
    end
    vecs++;
    if ({out_valid0, occ0} !== 3'b101 || out_data0 !== 32'hD) begin
      errs++;
      $display("FAIL release1_one: got v=%b occ=%0d data=%h want 1/1/d", out_valid0, occ0, out_data0);
    end
    step();
    vecs++;
    if ({out_valid1, occ1} !== 3'b101 || out_data1 !== 128'hD || out_ctrl1 !== 16'h00DD) begin
      errs++;
      $display("FAIL release2_skid: got v=%b occ=%0d ctrl=%h data=%h want 1/1/00dd/d",
               out_valid1, occ1, out_ctrl1, out_data1);
    end
    in_valid = 1'b0;
    step();
    vecs++;
    if ({out_valid1, occ1, in_ready1, out_valid0, occ0, in_ready0} !== 8'b00010001) begin
      errs++;
      $display("FAIL release_empty: got v1=%b o1=%0d r1=%b v0=%b o0=%0d r0=%b want 0/0/1/0/0/1",
               out_valid1, occ1, in_ready1, out_valid0, occ0, in_ready0);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 128'h1A; in_ctrl = 16'h0011;
    step();
    in_data = 128'h1B; in_ctrl = 16'h0012;
    step();
    vecs++;
    if (occ1 !== 2'd2) begin
      errs++;
      $display("FAIL flush_setup: got occ=%0d want 2", occ1);
    end
    in_data = 128'h1C; in_ctrl = 16'h0013; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vecs++;
    if ({out_valid1, occ1, in_ready1, out_ctrl1} !== {1'b0, 2'd0, 1'b1, 16'h0}) begin
      errs++;
      $display("FAIL flush_skid: got v=%b occ=%0d rdy=%b ctrl=%h want 0/0/1/0",
               out_valid1, occ1, in_ready1, out_ctrl1);
    end
    vecs++;
    if ({out_valid0, occ0, in_ready0, out_ctrl0} !== {1'b0, 2'd0, 1'b1, 5'h0}) begin
      errs++;
      $display("FAIL flush_one: got v=%b occ=%0d rdy=%b ctrl=%h want 0/0/1/0",
               out_valid0, occ0, in_ready0, out_ctrl0);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      vecs++;
      if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0 || out_data1 === 128'h1C) begin
        errs++;
        $display("FAIL flush_no_c%0d: got v1=%b v0=%b data=%h want 0/0/not 1c",
                 k, out_valid1, out_valid0, out_data1);
      end
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 16'hFFFF;
    in_data = 128'h21;
    step();
    vecs++;
    if (out_valid1 !== 1'b1 || out_ctrl1 !== 16'hFFFF || out_ctrl0 !== 5'h1F) begin
      errs++;
      $display("FAIL bubble_pre: got v=%b c1=%h c0=%h want 1/ffff/1f", out_valid1, out_ctrl1, out_ctrl0);
    end
    in_valid = 1'b0;
    step();
    vecs++;
    if ({out_valid1, out_ctrl1, out_valid0, out_ctrl0} !== {1'b0, 16'h0, 1'b0, 5'h0} ||
        out_data1 !== 128'h21) begin
      errs++;
      $display("FAIL bubble_hole: got v1=%b c1=%h v0=%b c0=%h d1=%h want 0/0000/0/00/21",
               out_valid1, out_ctrl1, out_valid0, out_ctrl0, out_data1);
    end
    in_valid = 1'b1; in_data = 128'h23;
    step();
    vecs++;
    if ({out_valid1, out_ctrl1, out_valid0, out_ctrl0} !== {1'b1, 16'hFFFF, 1'b1, 5'h1F} ||
        out_data1 !== 128'h23) begin
      errs++;
      $display("FAIL bubble_post: got v1=%b c1=%h v0=%b c0=%h d1=%h want 1/ffff/1/1f/23",
               out_valid1, out_ctrl1, out_valid0, out_ctrl0, out_data1);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0031;
    in_data = 128'h31;
    step();
    in_data = 128'h32;
    step();
    #3;
    clrn = 1'b1;
    #1;
    vecs++;
    if ({out_valid1, occ1, out_ctrl1} !== {1'b0, 2'd0, 16'h0} || out_data1 !== 128'h0 ||
        in_ready1 !== 1'b1) begin
      errs++;
      $display("FAIL async_rst_skid: got v=%b occ=%0d rdy=%b ctrl=%h data=%h want 0/0/1/0/0",
               out_valid1, occ1, in_ready1, out_ctrl1, out_data1);
    end
    vecs++;
    if ({out_valid0, occ0, out_ctrl0, out_data0} !== {1'b0, 2'd0, 5'h0, 32'h0}) begin
      errs++;
      $display("FAIL async_rst_one: got v=%b occ=%0d ctrl=%h data=%h want 0/0/0/0",
               out_valid0, occ0, out_ctrl0, out_data0);
    end
    step();
    clrn = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 128'(16'h40 + k);
      in_ctrl = 16'(k);
      step();
      vecs++;
      if ({out_valid1, occ1, in_ready1} !== 4'b1011 || out_data1 !== 128'(16'h40 + k) ||
          out_data0 !== 32'(16'h40 + k)) begin
        errs++;
        $display("FAIL restart k=%0d: got v=%b occ=%0d rdy=%b d1=%h d0=%h want 1/1/1/%h",
                 k, out_valid1, occ1, in_ready1, out_data1, out_data0, 16'h40 + k);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
